// File: rtl/col_input_ctrl.sv
// Column input controller: buffers one operand per PE row, then issues them down the column.
// Define COL_INPUT_CTRL_BCAST_EN to issue all rows in a single broadcast cycle.
module col_input_ctrl #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned INWIDTH = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [INWIDTH-1:0] in_w,
    input  logic               wvalid,
    output logic               wready,
    input  logic               flush,
    output logic [INWIDTH-1:0] out_d [0:ROWS-1],
    output logic               out_v [0:ROWS-1],
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    typedef enum logic {StFill, StIssue} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [INWIDTH-1:0] r_buf   [0:ROWS-1];
    logic [INWIDTH-1:0] r_out_d [0:ROWS-1];
    logic               r_out_v [0:ROWS-1];
    logic [CW-1:0]      r_icnt;
    logic               r_done;
    logic               w_accept;
`ifndef COL_INPUT_CTRL_BCAST_EN
    logic [CW-1:0]      r_ocnt;
`endif

    // rstn gates wready so nothing is accepted while reset is held
    assign wready   = rstn && (r_state == StFill);
    assign busy     = (r_state == StIssue);
    assign w_accept = wvalid && wready && !flush;
    assign done     = r_done;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            out_d[r] = r_out_d[r];
            out_v[r] = r_out_v[r];
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (flush) begin
            w_state_d = StFill;
        end else begin
            case (r_state)
                StFill: begin
                    if (w_accept && r_icnt == LAST) w_state_d = StIssue;
                end
                StIssue: begin
`ifdef COL_INPUT_CTRL_BCAST_EN
                    w_state_d = StFill;
`else
                    if (r_ocnt == LAST) w_state_d = StFill;
`endif
                end
                default: w_state_d = StFill;
            endcase
        end
    end

    // Operand storage is never reset or flushed; a full fill always precedes an issue.
    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_icnt] <= in_w;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= StFill;
            r_icnt  <= '0;
            r_done  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_out_v[r] <= 1'b0;
                r_out_d[r] <= '0;
            end
`ifndef COL_INPUT_CTRL_BCAST_EN
            r_ocnt  <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_done  <= 1'b0;
            for (int r = 0; r < ROWS; r++) r_out_v[r] <= 1'b0;
            if (flush) begin
                r_icnt <= '0;
`ifndef COL_INPUT_CTRL_BCAST_EN
                r_ocnt <= '0;
`endif
            end else if (w_accept) begin
                r_icnt <= (r_icnt == LAST) ? '0 : r_icnt + 1'b1;
            end else if (r_state == StIssue) begin
`ifdef COL_INPUT_CTRL_BCAST_EN
                for (int r = 0; r < ROWS; r++) begin
                    r_out_v[r] <= 1'b1;
                    r_out_d[r] <= r_buf[r];
                end
                r_done <= 1'b1;
`else
                r_out_v[r_ocnt] <= 1'b1;
                r_out_d[r_ocnt] <= r_buf[r_ocnt];
                if (r_ocnt == LAST) begin
                    r_ocnt <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_ocnt <= r_ocnt + 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_col_input_ctrl.sv
// Bench for col_input_ctrl (default staggered build): directed scenarios then random traffic,
// every cycle compared against a behavioural model of fill/issue.
module tb_col_input_ctrl;

    localparam int ROWS = 8;
    localparam int W    = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] in_w;
    logic         wvalid;
    logic         wready;
    logic         flush;
    logic [W-1:0] out_d [0:ROWS-1];
    logic         out_v [0:ROWS-1];
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: words collected so far, and which row is being issued.
    int           m_filled;
    bit           m_issuing;
    int           m_row;
    logic [W-1:0] m_buf [ROWS];
    logic [W-1:0] m_d   [ROWS];
    logic [ROWS-1:0] m_v;
    logic         m_done;

    col_input_ctrl #(.ROWS(ROWS), .INWIDTH(W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .in_w   (in_w),
        .wvalid (wvalid),
        .wready (wready),
        .flush  (flush),
        .out_d  (out_d),
        .out_v  (out_v),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_filled  = 0;
        m_issuing = 0;
        m_row     = 0;
        m_v       = '0;
        m_done    = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs, advance model across the edge.
    task automatic cyc(input logic v, input logic [W-1:0] w, input logic f, input logic rn);
        logic [ROWS-1:0] pv;
        wvalid = v;
        in_w   = w;
        flush  = f;
        rstn   = rn;
        #1;
        for (int r = 0; r < ROWS; r++) pv[r] = out_v[r];
        chk("wready", 32'(wready), 32'(rn && !m_issuing));
        chk("busy", 32'(busy), 32'(m_issuing));
        chk("done", 32'(done), 32'(m_done));
        chk("out_v", 32'(pv), 32'(m_v));
        for (int r = 0; r < ROWS; r++) chk($sformatf("out_d[%0d]", r), 32'(out_d[r]), 32'(m_d[r]));
        if (!rn) begin
            model_clear();
            for (int r = 0; r < ROWS; r++) m_d[r] = '0;
        end else if (f) begin
            model_clear();
        end else if (!m_issuing) begin
            m_v    = '0;
            m_done = 1'b0;
            if (v) begin
                m_buf[m_filled] = w;
                m_filled++;
                if (m_filled == ROWS) begin
                    m_filled  = 0;
                    m_issuing = 1;
                    m_row     = 0;
                end
            end
        end else begin
            m_v          = '0;
            m_v[m_row]   = 1'b1;
            m_d[m_row]   = m_buf[m_row];
            m_done       = (m_row == ROWS - 1);
            m_row++;
            if (m_row == ROWS) m_issuing = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        for (int r = 0; r < ROWS; r++) m_d[r] = '0;
        rstn = 1'b0; wvalid = 1'b0; flush = 1'b0; in_w = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, 16'hdead, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // Back-to-back fill 1..8, wvalid held through issue (must be ignored)
        for (int i = 0; i < ROWS; i++) cyc(1'b1, W'(i + 1), 1'b0, 1'b1);
        for (int i = 0; i < ROWS; i++) cyc(1'b1, 16'hbad0 + W'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Toggling wvalid fill
        for (int i = 0; i < 2 * ROWS; i++) cyc(1'(i % 2 == 0), 16'h0b00 + W'(i), 1'b0, 1'b1);
        for (int i = 0; i < ROWS + 2; i++) cyc(1'b1, 16'hee00 + W'(i), 1'b0, 1'b1);

        // Flush coinciding with 5th handshake, then load A0..A7
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0c00 + W'(i), 1'b0, 1'b1);
        cyc(1'b1, 16'h0c55, 1'b1, 1'b1);
        for (int i = 0; i < ROWS; i++) cyc(1'b1, 16'h00a0 + W'(i), 1'b0, 1'b1);
        for (int i = 0; i < ROWS + 2; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Flush in issue while out_v[2] is high
        for (int i = 0; i < ROWS; i++) cyc(1'b1, 16'h0d00 + W'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset mid-issue, then full reload
        for (int i = 0; i < ROWS; i++) cyc(1'b1, 16'h0e00 + W'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < ROWS; i++) cyc(1'b1, 16'h0f00 + W'(i), 1'b0, 1'b1);
        for (int i = 0; i < ROWS + 2; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), W'($urandom),
                1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 149) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
